// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding selects plus load-use stall/bubble control for the 5-stage core.
// Build option STALL_COUNTER_EN adds the stall_count output and its counter.
//
// state | meaning
// RUN   | normal issue; a load-use hazard inserts exactly one bubble into EX
// STALL | bubble issued; the dependent waits in ID until the load reaches WB
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  ex_ready,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall_id,
    output logic                  bubble_ex
`ifdef STALL_COUNTER_EN
    ,
    output logic [CNT_W-1:0]      stall_count
`endif
);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    state_t                state;
    logic [REG_ADDR_W-1:0] ex_rd, mem_rd, wb_rd;
    logic                  ex_wr, mem_wr, wb_wr;
    logic                  ex_load, mem_load, wb_load;

    logic rs1_ex, rs2_ex, rs1_mem, rs2_mem;
    logic hazard, issue;

    function automatic logic reg_match(input logic [REG_ADDR_W-1:0] rs,
                                       input logic                  used,
                                       input logic [REG_ADDR_W-1:0] rd,
                                       input logic                  wr);
        return wr && (rd == rs) && (rs != '0) && used;
    endfunction

    // The newer producer (EX) wins; a load in EX never forwards, it stalls instead.
    function automatic logic [1:0] sel_for(input logic m_ex, input logic m_mem, input logic ld_ex);
        if (m_ex && !ld_ex) return 2'd1;
        if (m_mem)          return 2'd2;
        return 2'd0;
    endfunction

    assign rs1_ex  = reg_match(id_rs1, id_rs1_used, ex_rd, ex_wr);
    assign rs2_ex  = reg_match(id_rs2, id_rs2_used, ex_rd, ex_wr);
    assign rs1_mem = reg_match(id_rs1, id_rs1_used, mem_rd, mem_wr);
    assign rs2_mem = reg_match(id_rs2, id_rs2_used, mem_rd, mem_wr);

    assign hazard    = id_valid && ex_load && (rs1_ex || rs2_ex);
    assign stall_id  = hazard || !ex_ready;
    assign bubble_ex = hazard && ex_ready && (state == RUN);
    assign issue     = id_valid && !stall_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            ex_rd     <= '0;
            ex_wr     <= 1'b0;
            ex_load   <= 1'b0;
            mem_rd    <= '0;
            mem_wr    <= 1'b0;
            mem_load  <= 1'b0;
            wb_rd     <= '0;
            wb_wr     <= 1'b0;
            wb_load   <= 1'b0;
            fwd_a_sel <= 2'd0;
            fwd_b_sel <= 2'd0;
        end else if (ex_ready) begin
            wb_rd    <= mem_rd;
            wb_wr    <= mem_wr;
            wb_load  <= mem_load;
            mem_rd   <= ex_rd;
            mem_wr   <= ex_wr;
            mem_load <= ex_load;
            if (issue) begin
                ex_rd     <= id_rd;
                ex_wr     <= id_reg_write;
                ex_load   <= id_is_load;
                fwd_a_sel <= sel_for(rs1_ex, rs1_mem, ex_load);
                fwd_b_sel <= sel_for(rs2_ex, rs2_mem, ex_load);
            end else begin
                ex_rd     <= '0;
                ex_wr     <= 1'b0;
                ex_load   <= 1'b0;
                fwd_a_sel <= 2'd0;
                fwd_b_sel <= 2'd0;
            end
            case (state)
                RUN:     if (hazard) state <= STALL;
                STALL:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // WB entry and the MEM load flag complete the tracking record but drive no decision.
    logic unused_track;
    assign unused_track = ^{wb_rd, wb_wr, wb_load, mem_load};

`ifdef STALL_COUNTER_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= '0;
        else if (stall_id)
            stall_count <= stall_count + CNT_W'(1);
    end
`else
    // CNT_W only sizes the counter; tie it off when the counter is absent.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed hazard scenarios plus randomized traffic
// against a history-based reference model.
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_reg_write, id_is_load;
    logic       ex_ready;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall_id, bubble_ex;
`ifdef STALL_COUNTER_EN
    logic [31:0] stall_count;
`endif

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .ex_ready     (ex_ready),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall_id     (stall_id),
        .bubble_ex    (bubble_ex)
`ifdef STALL_COUNTER_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  a;
        logic [1:0]  b;
        logic        stall;
        logic        bub;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } ent_t;

    exp_t sb[$];
    ent_t hist[$];          // instructions (or bubbles) that entered EX, newest last
    logic [1:0]  m_a, m_b;  // selects expected for the instruction now in EX
    logic        m_in_stall;
    logic [31:0] m_cnt;
    logic        m_stall;   // last predicted stall_id, used to hold the ID instruction
    int n_cmp = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    // age 1 = newest instruction in flight ahead of ID, age 2 = the one before it
    function automatic logic writes(input int age, input logic [4:0] rs);
        ent_t e;
        e = hist[hist.size() - age];
        return e.wr && (e.rd == rs);
    endfunction

    function automatic logic load_use(input logic [4:0] rs, input logic used);
        if (!used || rs == 5'd0) return 1'b0;
        return writes(1, rs) && hist[hist.size() - 1].ld;
    endfunction

    function automatic logic [1:0] src_of(input logic [4:0] rs, input logic used);
        if (!used || rs == 5'd0) return 2'd0;
        if (writes(1, rs)) return 2'd1;
        if (writes(2, rs)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic void model_reset();
        ent_t z;
        z.rd = 5'd0; z.wr = 1'b0; z.ld = 1'b0;
        hist.delete();
        hist.push_back(z);
        hist.push_back(z);
        m_a = 2'd0;
        m_b = 2'd0;
        m_in_stall = 1'b0;
        m_cnt = 32'd0;
        m_stall = 1'b0;
    endfunction

    // Drive one cycle of ID inputs, record the expected response, advance the model over the edge.
    task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic rdy);
        exp_t e;
        ent_t n;
        logic hz, bub;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        id_rd = rd; id_reg_write = wr; id_is_load = ld; ex_ready = rdy;
        hz  = v && (load_use(rs1, u1) || load_use(rs2, u2));
        m_stall = hz || !rdy;
        bub = hz && rdy && !m_in_stall;
        e.a = m_a; e.b = m_b; e.stall = m_stall; e.bub = bub; e.cnt = m_cnt;
        sb.push_back(e);
        if (rdy) begin
            if (v && !m_stall) begin
                m_a = src_of(rs1, u1);
                m_b = src_of(rs2, u2);
                n.rd = rd; n.wr = wr; n.ld = ld;
            end else begin
                m_a = 2'd0;
                m_b = 2'd0;
                n.rd = 5'd0; n.wr = 1'b0; n.ld = 1'b0;
            end
            hist.push_back(n);
            void'(hist.pop_front());
            m_in_stall = bub;
        end
        if (m_stall) m_cnt = m_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_rd = 5'd0; id_reg_write = 1'b0; id_is_load = 1'b0; ex_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_fwd_a"}, 32'(fwd_a_sel), 32'd0);
        chk({tag, "_fwd_b"}, 32'(fwd_b_sel), 32'd0);
        chk({tag, "_stall"}, 32'(stall_id), 32'd0);
        chk({tag, "_bubble"}, 32'(bubble_ex), 32'd0);
`ifdef STALL_COUNTER_EN
        chk({tag, "_count"}, stall_count, 32'd0);
`endif
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: every recorded cycle is compared against the DUT away from the active edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e.a));
            chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e.b));
            chk("stall_id", 32'(stall_id), 32'(e.stall));
            chk("bubble_ex", 32'(bubble_ex), 32'(e.bub));
`ifdef STALL_COUNTER_EN
            chk("stall_count", stall_count, e.cnt);
`endif
        end
    end

    logic [4:0] r_rs1, r_rs2, r_rd;
    logic       r_v, r_u1, r_u2, r_wr, r_ld, r_rdy;

    initial begin
        model_reset();
        do_reset("rst_init");

        // add x5 followed by a reader of x5: EX forward on A
        step(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 1);
        step(1, 5'd5, 5'd0, 1, 0, 5'd10, 1, 0, 1);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        // add x6, nop, sub rs2=x6: MEM/WB forward on B
        step(1, 5'd0, 5'd0, 0, 0, 5'd6, 1, 0, 1);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        step(1, 5'd1, 5'd6, 0, 1, 5'd11, 1, 0, 1);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        // lw x7; add rs1=x7: one bubble, then forward from WB
        step(1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 1, 1);
        step(1, 5'd7, 5'd0, 1, 0, 5'd12, 1, 0, 1);
        step(1, 5'd7, 5'd0, 1, 0, 5'd12, 1, 0, 1);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        // x0 producer and consumer
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 1);
        step(1, 5'd0, 5'd0, 1, 1, 5'd13, 1, 0, 1);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        // EX and MEM both write x9: newest wins on both operands
        step(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 1);
        step(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 1);
        step(1, 5'd9, 5'd9, 1, 1, 5'd14, 1, 0, 1);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        // load-use under a 3-cycle freeze, then a single bubble
        step(1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 1, 1);
        repeat (3) step(1, 5'd7, 5'd0, 1, 0, 5'd15, 1, 0, 0);
        step(1, 5'd7, 5'd0, 1, 0, 5'd15, 1, 0, 1);
        step(1, 5'd7, 5'd0, 1, 0, 5'd15, 1, 0, 1);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        // reset while in STALL
        step(1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 1, 1);
        step(1, 5'd0, 5'd7, 0, 1, 5'd16, 1, 0, 1);
        do_reset("rst_stall");
        step(1, 5'd7, 5'd7, 1, 1, 5'd17, 1, 0, 1);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);

        // Randomized traffic over a small register set; ID holds its instruction while stalled.
        r_v = 0; r_rs1 = 0; r_rs2 = 0; r_u1 = 0; r_u2 = 0; r_rd = 0; r_wr = 0; r_ld = 0;
        for (int i = 0; i < 600; i++) begin
            if (!m_stall) begin
                r_v   = ($urandom_range(0, 99) < 85);
                r_rs1 = 5'($urandom_range(0, 3));
                r_rs2 = 5'($urandom_range(0, 3));
                r_u1  = ($urandom_range(0, 99) < 80);
                r_u2  = ($urandom_range(0, 99) < 60);
                r_rd  = 5'($urandom_range(0, 3));
                r_wr  = ($urandom_range(0, 99) < 80);
                r_ld  = ($urandom_range(0, 99) < 35);
            end
            r_rdy = ($urandom_range(0, 99) < 80);
            step(r_v, r_rs1, r_rs2, r_u1, r_u2, r_rd, r_wr, r_ld, r_rdy);
        end

        repeat (2) @(posedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
